// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 mouse receive path: frame FSM states and decoded packet fields.
package ps2_pkg;
  localparam int PS2_DATA_BITS = 8;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

  typedef struct packed {
    logic [2:0] btns;
    logic [8:0] dx;
    logic [8:0] dy;
    logic       x_ovf;
    logic       y_ovf;
  } mouse_pkt_t;

  // b0 carries buttons, the delta sign bits and the overflow flags.
  function automatic mouse_pkt_t decode_pkt(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2);
    mouse_pkt_t p;
    p.btns  = b0[2:0];
    p.dx    = {b0[4], b1};
    p.dy    = {b0[5], b2};
    p.x_ovf = b0[6];
    p.y_ovf = b0[7];
    return p;
  endfunction
endpackage

// File: rtl/ps2_mouse_rx_if.sv
// Decoded byte/packet/error outputs of the PS/2 mouse receiver.
interface ps2_mouse_rx_if;
  logic              byte_valid;
  logic [7:0]        byte_out;
  logic              packet_valid;
  logic              btn_left;
  logic              btn_right;
  logic              btn_middle;
  logic signed [8:0] dx;
  logic signed [8:0] dy;
  logic              x_ovf;
  logic              y_ovf;
  logic              frame_err;
  logic              sync_err;

  modport master (output byte_valid, byte_out, packet_valid, btn_left, btn_right, btn_middle,
                         dx, dy, x_ovf, y_ovf, frame_err, sync_err);
  modport slave  (input  byte_valid, byte_out, packet_valid, btn_left, btn_right, btn_middle,
                         dx, dy, x_ovf, y_ovf, frame_err, sync_err);
endinterface

// File: rtl/ps2_byte_rx.sv
// Synchronises raw PS/2 clock/data and deserialises 11-bit frames (start, 8 data, odd parity, stop).
module ps2_byte_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] c_sync_q, d_sync_q;
  logic                   ps2c_q;
  logic                   ps2c_s, ps2d_s, fall;

  // Idle-high reset values keep a spurious falling edge from appearing out of reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      c_sync_q <= '1;
      d_sync_q <= '1;
      ps2c_q   <= 1'b1;
    end else begin
      c_sync_q <= {c_sync_q[SYNC_STAGES-2:0], ps2c_i};
      d_sync_q <= {d_sync_q[SYNC_STAGES-2:0], ps2d_i};
      ps2c_q   <= ps2c_s;
    end
  end

  assign ps2c_s = c_sync_q[SYNC_STAGES-1];
  assign ps2d_s = d_sync_q[SYNC_STAGES-1];
  assign fall   = ps2c_q & ~ps2c_s;

  frame_state_t                   state_q, state_d;
  logic [2:0]                     bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0]       shift_q, shift_d;
  logic                           perr_q, perr_d;
  logic [CW-1:0]                  idle_cnt_q, idle_cnt_d;
  logic [PS2_DATA_BITS-1:0]       byte_q, byte_d;
  logic                           bv_q, bv_d, fe_q, fe_d;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      idle_cnt_q <= '0;
      byte_q     <= '0;
      bv_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      idle_cnt_q <= idle_cnt_d;
      byte_q     <= byte_d;
      bv_q       <= bv_d;
      fe_q       <= fe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    byte_d     = byte_q;
    bv_d       = 1'b0;
    fe_d       = 1'b0;
    // Saturate so a long idle line never wraps back into a false count.
    idle_cnt_d = fall ? '0 : ((idle_cnt_q == TMAX) ? idle_cnt_q : idle_cnt_q + CW'(1));
    if (fall) begin
      unique case (state_q)
        IDLE: if (!ps2d_s) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d   = {ps2d_s, shift_q[PS2_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          perr_d  = ~(^shift_q ^ ps2d_s);
          state_d = STOP;
        end
        STOP: begin
          if (ps2d_s && !perr_q) begin
            byte_d = shift_q;
            bv_d   = 1'b1;
          end else begin
            fe_d   = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && idle_cnt_q == TMAX) begin
      state_d = IDLE;
      fe_d    = 1'b1;
    end
  end

  assign byte_valid_o = bv_q;
  assign byte_o       = byte_q;
  assign frame_err_o  = fe_q;
endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse front end: byte receiver plus 3-byte packet assembler with one-cycle strobes.
module ps2_mouse_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          clk_ps2_raw,
  input  logic          ps2_data,
  ps2_mouse_rx_if.master mouse_o
);
  logic       bv, fe;
  logic [7:0] byte_w;

  ps2_byte_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_byte_rx (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .ps2c_i      (clk_ps2_raw),
    .ps2d_i      (ps2_data),
    .byte_valid_o(bv),
    .byte_o      (byte_w),
    .frame_err_o (fe)
  );

  logic [1:0] idx_q, idx_d;
  logic [7:0] b0_q, b0_d, b1_q, b1_d;
  mouse_pkt_t pkt_q, pkt_d;
  logic       pv_q, pv_d, se_q, se_d;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      idx_q <= '0;
      b0_q  <= '0;
      b1_q  <= '0;
      pkt_q <= '0;
      pv_q  <= 1'b0;
      se_q  <= 1'b0;
    end else begin
      idx_q <= idx_d;
      b0_q  <= b0_d;
      b1_q  <= b1_d;
      pkt_q <= pkt_d;
      pv_q  <= pv_d;
      se_q  <= se_d;
    end
  end

  always_comb begin
    idx_d = idx_q;
    b0_d  = b0_q;
    b1_d  = b1_q;
    pkt_d = pkt_q;
    pv_d  = 1'b0;
    se_d  = 1'b0;
    if (fe) begin
      idx_d = '0;
    end else if (bv) begin
      unique case (idx_q)
        2'd0: if (byte_w[3]) begin
          b0_d  = byte_w;
          idx_d = 2'd1;
        end else begin
          se_d  = 1'b1;
        end
        2'd1: begin
          b1_d  = byte_w;
          idx_d = 2'd2;
        end
        default: begin
          pkt_d = decode_pkt(b0_q, b1_q, byte_w);
          pv_d  = 1'b1;
          idx_d = '0;
        end
      endcase
    end
  end

  assign mouse_o.byte_valid   = bv;
  assign mouse_o.byte_out     = byte_w;
  assign mouse_o.frame_err    = fe;
  assign mouse_o.packet_valid = pv_q;
  assign mouse_o.sync_err     = se_q;
  assign mouse_o.btn_left     = pkt_q.btns[0];
  assign mouse_o.btn_right    = pkt_q.btns[1];
  assign mouse_o.btn_middle   = pkt_q.btns[2];
  assign mouse_o.dx           = pkt_q.dx;
  assign mouse_o.dy           = pkt_q.dy;
  assign mouse_o.x_ovf        = pkt_q.x_ovf;
  assign mouse_o.y_ovf        = pkt_q.y_ovf;
endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Drives bit-level PS/2 frames into ps2_mouse_rx and compares against a frame-level mouse model.
module tb_ps2_mouse_rx;
  localparam int TO   = 500;
  localparam int HALF = 50;

  logic clk_in = 1'b0, rst_n_in = 1'b0, ps2c = 1'b1, ps2d = 1'b1;
  ps2_mouse_rx_if mif();

  ps2_mouse_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .clk_ps2_raw(ps2c),
    .ps2_data   (ps2d),
    .mouse_o    (mif)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0, n_err = 0;
  int cyc = 0, last_fall = 0, fe_cyc = 0;
  int bv_n = 0, pv_n = 0, fe_n = 0, se_n = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Count high cycles of each strobe; a stretched pulse shows up as an extra count.
  always @(negedge clk_in) begin
    if (mif.byte_valid)   bv_n <= bv_n + 1;
    if (mif.packet_valid) pv_n <= pv_n + 1;
    if (mif.sync_err)     se_n <= se_n + 1;
    if (mif.frame_err) begin
      fe_n   <= fe_n + 1;
      fe_cyc <= cyc;
    end
  end

  // Frame-level reference model.
  int         m_idx = 0, e_bv = 0, e_pv = 0, e_fe = 0, e_se = 0;
  logic [7:0] m_b0 = '0, m_b1 = '0, e_byte = '0;
  logic [2:0] e_btn = '0;
  logic [8:0] e_dx = '0, e_dy = '0;
  logic       e_xo = 1'b0, e_yo = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2d = b;
    wait_cyc(HALF / 2);
    ps2c = 1'b0;
    last_fall = cyc;
    wait_cyc(HALF);
    ps2c = 1'b1;
    wait_cyc(HALF / 2);
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      e_fe++;
      m_idx = 0;
    end else begin
      e_bv++;
      e_byte = b;
      if (m_idx == 0) begin
        if (b[3]) begin m_b0 = b; m_idx = 1; end
        else e_se++;
      end else if (m_idx == 1) begin
        m_b1 = b; m_idx = 2;
      end else begin
        e_pv++;
        e_btn = m_b0[2:0];
        e_dx  = {m_b0[4], m_b1};
        e_dy  = {m_b0[5], b};
        e_xo  = m_b0[6];
        e_yo  = m_b0[7];
        m_idx = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".bv"},   bv_n, e_bv);
    check({tag, ".fe"},   fe_n, e_fe);
    check({tag, ".se"},   se_n, e_se);
    check({tag, ".pv"},   pv_n, e_pv);
    check({tag, ".byte"}, mif.byte_out, e_byte);
    check({tag, ".btn"},  {mif.btn_middle, mif.btn_right, mif.btn_left}, e_btn);
    check({tag, ".dx"},   {mif.dx}, e_dx);
    check({tag, ".dy"},   {mif.dy}, e_dy);
    check({tag, ".ovf"},  {mif.y_ovf, mif.x_ovf}, {e_yo, e_xo});
  endtask

  task automatic send_frame(input string tag, input logic [7:0] b, input bit bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    wait_cyc(20);
    model_frame(b, !bad_par);
    check_all(tag);
  endtask

  task automatic check_outs_zero(input string tag);
    check(tag, {mif.byte_valid, mif.byte_out, mif.packet_valid, mif.btn_left, mif.btn_right,
                mif.btn_middle, mif.dx, mif.dy, mif.x_ovf, mif.y_ovf, mif.frame_err,
                mif.sync_err}, 64'd0);
  endtask

  initial begin
    logic [10:0] f;
    logic [7:0]  rb;
    #1;
    check_outs_zero("reset");
    wait_cyc(5);
    rst_n_in = 1'b1;
    wait_cyc(10);
    check_all("idle");

    // 1: basic packet
    send_frame("t1b0", 8'h08, 0);
    send_frame("t1b1", 8'h55, 0);
    send_frame("t1b2", 8'hAA, 0);
    // 2: left button, negative dy
    send_frame("t2b0", 8'h29, 0);
    send_frame("t2b1", 8'hFF, 0);
    send_frame("t2b2", 8'hFF, 0);
    // 3: parity error discards partial packet
    send_frame("t3b0", 8'h08, 0);
    send_frame("t3bad", 8'h55, 1);
    send_frame("t3c0", 8'h08, 0);
    send_frame("t3c1", 8'h01, 0);
    send_frame("t3c2", 8'h02, 0);
    // 4: bad byte0 candidate
    send_frame("t4drop", 8'h00, 0);
    send_frame("t4b0", 8'h09, 0);
    send_frame("t4b1", 8'h10, 0);
    send_frame("t4b2", 8'h20, 0);

    // 5: timeout mid-frame after a valid byte0
    send_frame("t5b0", 8'h08, 0);
    f = {1'b1, 1'b0, 8'h0F, 1'b0};
    for (int i = 0; i < 5; i++) ps2_bit(f[i]);
    wait_cyc(600);
    e_fe++;
    m_idx = 0;
    check_all("t5to");
    check("t5to.lat_hi", 64'((fe_cyc - last_fall) <= 508), 64'd1);
    check("t5to.lat_lo", 64'((fe_cyc - last_fall) >= 495), 64'd1);
    send_frame("t5c0", 8'h3B, 0);
    send_frame("t5c1", 8'h80, 0);
    send_frame("t5c2", 8'h7F, 0);

    // Randomised packets, occasional parity errors and sync drops
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 3; k++) begin
        rb = 8'($urandom);
        if (k == 0 && $urandom_range(0, 3) != 0) rb[3] = 1'b1;
        send_frame($sformatf("rnd%0d_%0d", p, k), rb, $urandom_range(0, 7) == 0);
      end
    end

    // 6: reset in the middle of byte2
    send_frame("t6b0", 8'hC8, 0);
    send_frame("t6b1", 8'h03, 0);
    f = {1'b1, 1'b1, 8'h44, 1'b0};
    for (int i = 0; i < 6; i++) ps2_bit(f[i]);
    rst_n_in = 1'b0;
    #1;
    check_outs_zero("t6rst");
    m_idx = 0; e_byte = '0; e_btn = '0; e_dx = '0; e_dy = '0; e_xo = 1'b0; e_yo = 1'b0;
    ps2c = 1'b1;
    ps2d = 1'b1;
    wait_cyc(5);
    rst_n_in = 1'b1;
    wait_cyc(200);
    check_all("t6rel");
    send_frame("t6c0", 8'h18, 0);
    send_frame("t6c1", 8'h7F, 0);
    send_frame("t6c2", 8'h80, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, observed running expected finished");
    $fatal(1);
  end
endmodule
